// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
// The optional parity output is enabled with the MUX_SCAN_PARITY_EN macro in mux_scan_seq.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mux_scan_pick.sv
// Combinational channel picker: lowest enabled channel above ch, or the lowest
// enabled channel overall when from_start is set.
module mux_scan_pick
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  ch,
    input  logic              from_start,
    output logic [SEL_W-1:0]  next_ch,
    output logic              found
);

    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        // Walk downward so the lowest qualifying channel is the last one written.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (from_start || (k > int'(ch)))) begin
                next_ch = SEL_W'(k);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 4:1 mux: steps the select lines through enabled channels and samples each.
// Define MUX_SCAN_PARITY_EN to add a registered parity output (^data) updated with done.
//
// state  | meaning
// IDLE   | waiting for start; select parked at channel 0
// SELECT | drive select lines to the current channel, load settle counter
// SETTLE | count down the settle interval
// SAMPLE | capture mux_out into data[ch], pick next channel
// DONE   | one-cycle done pulse, select holds last channel
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              mux_out,
    output logic              s0,
    output logic              s1,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] data
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              parity
`endif
);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   data_q, data_d;
`ifdef MUX_SCAN_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic                in_idle;
    logic [NUM_CH-1:0]   pick_mask;
    logic [SEL_W-1:0]    pick_ch;
    logic                pick_found;

    // One picker serves both the first-channel search (live mask) and the next-channel search.
    assign in_idle   = (state_q == ST_IDLE);
    assign pick_mask = in_idle ? ch_mask : mask_q;

    mux_scan_pick u_pick (
        .mask       (pick_mask),
        .ch         (ch_q),
        .from_start (in_idle),
        .next_ch    (pick_ch),
        .found      (pick_found)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        data_d  = data_q;
`ifdef MUX_SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    busy_d = 1'b1;
                    data_d = '0;
                    if (pick_found) begin
                        state_d = ST_SELECT;
                        mask_d  = ch_mask;
                        ch_d    = pick_ch;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        parity_d = 1'b0;
`endif
                    end
                end
            end
            ST_SELECT: begin
                sel_d   = ch_q;
                cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                data_d[ch_q] = mux_out;
                if (pick_found) begin
                    ch_d    = pick_ch;
                    state_d = ST_SELECT;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    parity_d = ^data_d;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sel_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sel_d   = '0;
            end
        endcase

        // DONE is excluded: its pulse is already on the output and the return is normal.
        if (abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            data_d  = '0;
            sel_d   = '0;
            cnt_d   = '0;
`ifdef MUX_SCAN_PARITY_EN
            parity_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign s0   = sel_q[0];
    assign s1   = sel_q[1];
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;
`ifdef MUX_SCAN_PARITY_EN
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench for mux_scan_seq: stimulus pushes expected scan results, a monitor checks each done.
module tb_mux_scan_seq;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] ch_mask;
    logic       mux_out;
    logic       s0, s1, busy, done;
    logic [3:0] data;
`ifdef MUX_SCAN_PARITY_EN
    logic       parity;
`endif

    logic [3:0] ins;
    logic [1:0] sel_now;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] data;
        int         lat;
        int         start_cyc;
        int         seq_code;
        int         seq_n;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] last_data;

    always #5 clk = ~clk;

    assign sel_now = {s1, s0};
    assign mux_out = ins[sel_now];

    mux_scan_seq #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .ch_mask (ch_mask),
        .mux_out (mux_out),
        .s0      (s0),
        .s1      (s1),
        .busy    (busy),
        .done    (done),
        .data    (data)
`ifdef MUX_SCAN_PARITY_EN
        ,
        .parity  (parity)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: each enabled channel is visited in ascending order, select starts parked at 0,
    // and every visited channel costs a select cycle, the settle interval and a sample cycle.
    function automatic exp_t model(input logic [3:0] m, input logic [3:0] iv, input int sc);
        exp_t e;
        int   last;
        e.data      = m & iv;
        e.lat       = $countones(m) * (SETTLE + 2);
        e.start_cyc = sc;
        e.seq_code  = 0;
        e.seq_n     = 1;
        last        = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[k] && k != last) begin
                e.seq_code = e.seq_code * 4 + k;
                e.seq_n++;
                last = k;
            end
        end
        return e;
    endfunction

    // Monitor: samples 1 time unit after every rising edge.
    int         obs_code, obs_n;
    logic [1:0] obs_last;
    logic       prev_busy = 1'b0, prev_done = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                obs_code = 0;
                obs_n    = 0;
            end
            if (busy && (obs_n == 0 || sel_now != obs_last)) begin
                obs_code = obs_code * 4 + int'(sel_now);
                obs_n++;
                obs_last = sel_now;
            end
            if (prev_done) begin
                chk("post_done_idle", {28'd0, busy, done, s1, s0}, 32'd0);
                chk("post_done_data_hold", {28'd0, data}, {28'd0, last_data});
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("scan_data", {28'd0, data}, {28'd0, e.data});
                    chk("done_latency", cyc - e.start_cyc, e.lat);
                    chk("select_order", obs_code, e.seq_code);
                    chk("select_count", obs_n, e.seq_n);
                    chk("busy_with_done", {31'd0, busy}, 32'd1);
`ifdef MUX_SCAN_PARITY_EN
                    chk("parity", {31'd0, parity}, {31'd0, ^e.data});
`endif
                end
            end
            prev_done = done;
            prev_busy = busy;
        end
    end

    task automatic issue_start(input logic [3:0] m, input logic [3:0] iv);
        @(negedge clk);
        ins     = iv;
        ch_mask = m;
        start   = 1'b1;
        exp_q.push_back(model(m, iv, cyc + 1));
        last_data = m & iv;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit wiggle);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            if (wiggle) ch_mask = 4'($urandom);
            n++;
        end
        if (n >= budget) begin
            chk("wait_idle_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("wait_done_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_cleared(input string name);
        chk(name, {24'd0, busy, done, s1, s0, data}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        ch_mask = 4'h0;
        ins     = 4'h0;
        last_data = 4'h0;
        repeat (3) @(negedge clk);
        check_cleared("reset_values");
        rst_n = 1'b1;

        // Full scan, sparse scan, empty scan with the reference mux pattern i0..i3 = 0,1,1,0.
        issue_start(4'hF, 4'b0110);
        wait_idle(60, 1'b0);
        issue_start(4'b1010, 4'b0110);
        wait_idle(60, 1'b0);
        issue_start(4'b0000, 4'b0110);
        wait_idle(60, 1'b0);

        // Abort before edge 5 of a full scan after channel 0 has been sampled.
        issue_start(4'hF, 4'b1111);
        repeat (4) @(negedge clk);
        chk("pre_abort_data", {28'd0, data}, 32'd1);
        abort = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        abort = 1'b0;
        check_cleared("abort_clear");
        last_data = 4'h0;
        repeat (3) @(negedge clk);

        // Asynchronous reset between edges in the middle of a scan.
        issue_start(4'hF, 4'b1111);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_cleared("async_reset_clear");
        exp_q.delete();
        last_data = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {31'd0, busy}, 32'd0);

        // Start held through the scan; mask change mid-scan must be ignored.
        @(negedge clk);
        ins     = 4'b0110;
        ch_mask = 4'hF;
        start   = 1'b1;
        exp_q.push_back(model(4'hF, 4'b0110, cyc + 1));
        last_data = 4'b0110;
        repeat (3) @(negedge clk);
        ch_mask = 4'h1;
        wait_done(40);
        @(negedge clk);
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        exp_q.push_back(model(4'h1, 4'b0110, cyc + 1));
        @(negedge clk);
        last_data = 4'b0110 & 4'h1;
        start = 1'b0;
        wait_idle(60, 1'b0);

        // Abort and start together in IDLE: abort wins and data holds.
        @(negedge clk);
        ch_mask = 4'hF;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", {24'd0, busy, done, s1, s0, data}, {28'd0, last_data});

        // Abort during the done cycle: pulse already out, normal return, data kept.
        issue_start(4'b0101, 4'b1111);
        wait_done(40);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_done", {24'd0, busy, done, s1, s0, data}, 32'b0101);
        repeat (2) @(negedge clk);

        // Randomized scans with mask noise during the scan and occasional aborts.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] m, iv;
            exp_t       e;
            m  = 4'($urandom);
            iv = 4'($urandom);
            issue_start(m, iv);
            e = model(m, iv, 0);
            if (e.lat > 2 && $urandom_range(0, 3) == 0) begin
                int r;
                r = $urandom_range(1, e.lat - 1);
                repeat (r - 1) begin
                    @(negedge clk);
                    ch_mask = 4'($urandom);
                end
                abort = 1'b1;
                void'(exp_q.pop_back());
                @(negedge clk);
                abort = 1'b0;
                check_cleared("random_abort_clear");
                last_data = 4'h0;
            end else begin
                wait_idle(60, 1'b1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
